// File: rtl/store_buffer.sv
// Circular store buffer between the pipeline and data memory.
// Stores drain in FIFO order; ld_hit_o flags a pending write to the same aligned word as a load.
module store_buffer #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned DEPTH = 4
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      enq_valid_i,
   output logic                      enq_ready_o,
   input  logic [XLEN-1:0]           enq_addr_i,
   input  logic [XLEN-1:0]           enq_data_i,
   input  logic [1:0]                enq_size_i,
   output logic                      misalign_o,
   output logic                      mem_req_o,
   input  logic                      mem_gnt_i,
   output logic [XLEN-1:0]           mem_addr_o,
   output logic [XLEN-1:0]           mem_wdata_o,
   output logic [XLEN/8-1:0]         mem_be_o,
   input  logic [XLEN-1:0]           ld_addr_i,
   output logic                      ld_hit_o,
   output logic [$clog2(DEPTH):0]    count_o
);

   localparam int unsigned NB = XLEN / 8;
   localparam int unsigned OW = $clog2(NB);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [XLEN-1:0] addr_q  [DEPTH];
   logic [XLEN-1:0] data_q  [DEPTH];
   logic [NB-1:0]   be_q    [DEPTH];

   logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic            misaligned, push, pop;
   logic [OW-1:0]   offset;
   logic [7:0]      size_mask;
   logic [NB-1:0]   enq_be;
   logic [XLEN-1:0] enq_wdata, enq_word, ld_word;
   logic [PW-1:0]   rel;

   assign offset   = enq_addr_i[OW-1:0];
   assign enq_word = {enq_addr_i[XLEN-1:OW], {OW{1'b0}}};
   assign ld_word  = {ld_addr_i[XLEN-1:OW], {OW{1'b0}}};

   always_comb begin
      misaligned = 1'b0;
      size_mask  = 8'h01;
      case (enq_size_i)
         2'b00: begin
            misaligned = 1'b0;
            size_mask  = 8'h01;
         end
         2'b01: begin
            misaligned = enq_addr_i[0];
            size_mask  = 8'h03;
         end
         2'b10: begin
            misaligned = |enq_addr_i[1:0];
            size_mask  = 8'h0F;
         end
         default: begin
            // Doubleword stores only exist on a 64-bit datapath.
            misaligned = (XLEN == 32) || (|enq_addr_i[2:0]);
            size_mask  = 8'hFF;
         end
      endcase
   end

   assign enq_be    = size_mask[NB-1:0] << offset;
   assign enq_wdata = enq_data_i << {offset, 3'b000};

   assign enq_ready_o = (count_q < CW'(DEPTH));
   assign misalign_o  = enq_valid_i & misaligned;
   assign mem_req_o   = (count_q != '0);
   assign push        = enq_valid_i & enq_ready_o & ~misaligned;
   assign pop         = mem_req_o & mem_gnt_i;
   assign count_o     = count_q;

   assign mem_addr_o  = mem_req_o ? addr_q[rd_ptr_q] : '0;
   assign mem_wdata_o = mem_req_o ? data_q[rd_ptr_q] : '0;
   assign mem_be_o    = mem_req_o ? be_q[rd_ptr_q]   : '0;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d  = count_q + CW'(push) - CW'(pop);
   end

   // An entry is live when its distance from the head is below the occupancy.
   always_comb begin
      ld_hit_o = 1'b0;
      rel      = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         rel = PW'(i) - rd_ptr_q;
         if (({1'b0, rel} < count_q) && (addr_q[i] == ld_word)) begin
            ld_hit_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_q[wr_ptr_q] <= enq_word;
         data_q[wr_ptr_q] <= enq_wdata;
         be_q[wr_ptr_q]   <= enq_be;
      end
   end

endmodule
